// File: rtl/cpu_issue_scoreboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_issue_scoreboard                                                      |
// | Register scoreboard and issue gate between decode and execute; tracks     |
// | pending destinations, caps in-flight writers and drains for serializing   |
// | instructions. Optional same-cycle writeback bypass: CPU_SCOREBOARD_BYPASS_EN|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module cpu_issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [1:0]  i_have_rs,
  input  logic [4:0]  i_rd,
  input  logic        i_have_rd,
  input  logic        i_serialize,
  input  logic        i_flush,
  input  logic        i_wb_strobe,
  input  logic [4:0]  i_wb_rd,
  output logic        o_issue,
  output logic        o_stall,
  output logic [31:0] o_pending,
  output logic [3:0]  o_inflight,
  output logic        o_fault
);

  localparam logic [3:0] c_max_inflight = 4'(MAX_INFLIGHT);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pending;
  logic [3:0]  r_inflight;
  logic        r_fault;

  logic        w_writer;
  logic        w_wb_live;
  logic        w_wb_hit;
  logic        w_wb_bad;
  logic [31:0] w_wb_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_pend_view;
  logic [3:0]  w_cnt_view;
  logic        w_hazard;
  logic        w_issue;
  logic        w_inc;

  assign w_writer  = i_have_rd & (i_rd != 5'd0);
  assign w_wb_live = i_wb_strobe & (i_wb_rd != 5'd0);
  assign w_wb_hit  = w_wb_live & r_pending[i_wb_rd];
  assign w_wb_bad  = w_wb_live & ~r_pending[i_wb_rd];
  assign w_wb_mask = w_wb_hit ? (32'd1 << i_wb_rd) : 32'd0;

`ifdef CPU_SCOREBOARD_BYPASS_EN
  // A retiring writer frees its register and its slot within the same cycle.
  assign w_pend_view = r_pending & ~w_wb_mask;
  assign w_cnt_view  = r_inflight - {3'd0, w_wb_hit};
`else
  assign w_pend_view = r_pending;
  assign w_cnt_view  = r_inflight;
`endif

  assign w_hazard = (i_have_rs[0] & w_pend_view[i_rs1])
                  | (i_have_rs[1] & w_pend_view[i_rs2])
                  | (w_writer & w_pend_view[i_rd])
                  | (w_writer & (w_cnt_view == c_max_inflight));

  always_comb begin
    w_issue      = 1'b0;
    w_state_next = r_state;
    case (r_state)
      S_RUN: begin
        w_issue = i_valid & ~i_flush & ~w_hazard & ~i_serialize;
        if (i_valid & i_serialize & ~i_flush) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_issue = i_valid & ~i_flush & ~w_hazard & (r_inflight == 4'd0);
        if (w_issue | i_flush | ~i_valid) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  assign w_inc      = w_issue & w_writer;
  assign w_set_mask = w_inc ? (32'd1 << i_rd) : 32'd0;

  // Clear before set so a same-register issue/writeback pair leaves the bit set.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_RUN;
      r_pending  <= 32'd0;
      r_inflight <= 4'd0;
      r_fault    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= ((r_pending & ~w_wb_mask) | w_set_mask) & ~32'd1;
      case ({w_inc, w_wb_hit})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
      r_fault <= r_fault | w_wb_bad;
    end
  end

  assign o_issue    = w_issue;
  assign o_stall    = i_valid & ~w_issue & ~i_flush;
  assign o_pending  = r_pending;
  assign o_inflight = r_inflight;
  assign o_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_issue_scoreboard.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_cpu_issue_scoreboard                                                   |
// | Self-checking bench: reference model feeds an expectation queue per cycle.|
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_cpu_issue_scoreboard;

  localparam int MAXI = 2;
`ifdef CPU_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0, i_wb_rd = '0;
  logic [1:0]  i_have_rs = '0;
  logic        i_have_rd = 1'b0, i_serialize = 1'b0, i_flush = 1'b0, i_wb_strobe = 1'b0;
  logic        o_issue, o_stall, o_fault;
  logic [31:0] o_pending;
  logic [3:0]  o_inflight;

  cpu_issue_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_have_rs(i_have_rs),
    .i_rd(i_rd), .i_have_rd(i_have_rd), .i_serialize(i_serialize),
    .i_flush(i_flush), .i_wb_strobe(i_wb_strobe), .i_wb_rd(i_wb_rd),
    .o_issue(o_issue), .o_stall(o_stall), .o_pending(o_pending),
    .o_inflight(o_inflight), .o_fault(o_fault)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic        issue;
    logic        stall;
    logic [31:0] pend;
    logic [3:0]  cnt;
    logic        fault;
    logic        drain;
  } exp_t;

  exp_t        q_exp[$];
  logic [31:0] m_pend  = '0;
  logic [3:0]  m_cnt   = '0;
  logic        m_fault = 1'b0;
  logic        m_drain = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_cnt = '0; m_fault = 1'b0; m_drain = 1'b0;
  endtask

  // One cycle: drive at posedge+1, check combinational and state at negedge, advance model.
  task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [1:0] hrs, input logic [4:0] rd, input logic hrd,
                      input logic ser, input logic fl, input logic wbs, input logic [4:0] wbrd);
    logic        writer, hit, bad, hazard, iss;
    logic [31:0] pv;
    logic [3:0]  cv;
    exp_t        e;
    i_valid = v; i_rs1 = rs1; i_rs2 = rs2; i_have_rs = hrs; i_rd = rd;
    i_have_rd = hrd; i_serialize = ser; i_flush = fl; i_wb_strobe = wbs; i_wb_rd = wbrd;
    writer = hrd && (rd != 0);
    hit    = wbs && (wbrd != 0) && m_pend[wbrd];
    bad    = wbs && (wbrd != 0) && !m_pend[wbrd];
    pv     = (BYP && hit) ? (m_pend & ~(32'd1 << wbrd)) : m_pend;
    cv     = (BYP && hit) ? m_cnt - 4'd1 : m_cnt;
    hazard = (hrs[0] && pv[rs1]) || (hrs[1] && pv[rs2]) || (writer && pv[rd])
          || (writer && (cv == 4'(MAXI)));
    if (!m_drain) iss = v && !fl && !hazard && !ser;
    else          iss = v && !fl && !hazard && (m_cnt == 0);
    e = '{issue: iss, stall: v && !iss && !fl, pend: m_pend, cnt: m_cnt,
          fault: m_fault, drain: m_drain};
    q_exp.push_back(e);
    @(negedge i_clock);
    e = q_exp.pop_front();
    chk("issue",    {31'd0, o_issue},    {31'd0, e.issue});
    chk("stall",    {31'd0, o_stall},    {31'd0, e.stall});
    chk("pending",  o_pending,           e.pend);
    chk("inflight", {28'd0, o_inflight}, {28'd0, e.cnt});
    chk("fault",    {31'd0, o_fault},    {31'd0, e.fault});
    chk("state",    32'(dut.r_state),    {31'd0, e.drain});
    if (!m_drain) m_drain = v && ser && !fl;
    else if (iss || fl || !v) m_drain = 1'b0;
    if (hit) m_pend[wbrd] = 1'b0;
    if (iss && writer) m_pend[rd] = 1'b1;
    m_cnt   = m_cnt + 4'(iss && writer) - 4'(hit);
    m_fault = m_fault || bad;
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input logic wbs, input logic [4:0] wbrd);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, wbs, wbrd);
  endtask

  task automatic wr(input logic [4:0] rd, input logic wbs, input logic [4:0] wbrd);
    step(1, 0, 0, 2'b00, rd, 1, 0, 0, wbs, wbrd);
  endtask

  initial begin
    logic [4:0] pick;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    model_reset();

    // Reset state and a first writer issuing in the same cycle.
    idle(0, 0);
    wr(5, 0, 0);
    chk("t1_pend5", {31'd0, o_pending[5]}, 32'd1);
    chk("t1_cnt",   {28'd0, o_inflight}, 32'd1);

    // Dependent on rd=5: stalls until the writeback releases it.
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 1, 5);
    step(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("t2_pend5", {31'd0, o_pending[5]}, 32'd0);

    // In-flight cap of two writers.
    wr(1, 0, 0);
    wr(2, 0, 0);
    wr(3, 0, 0);
    wr(3, 0, 0);
    wr(3, 1, 1);
    wr(3, 0, 0);
    chk("t3_cnt", {28'd0, o_inflight}, 32'd2);

    // Serialize with two in flight drains first.
    step(1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 1, 0, 1, 2);
    step(1, 0, 0, 2'b00, 0, 0, 1, 0, 1, 3);
    step(1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // Randomised traffic; writebacks only target pending registers.
    for (int n = 0; n < 300; n++) begin
      logic wbs;
      wbs  = 1'b0;
      pick = 5'($urandom_range(1, 31));
      if (m_pend != 0 && $urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 32; k++) begin
          if (!wbs && m_pend[pick]) wbs = 1'b1;
          else if (!wbs) pick = (pick == 31) ? 5'd1 : pick + 5'd1;
        end
      end
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), wbs, pick);
    end
    for (int n = 0; n < 4; n++) begin
      for (int r = 1; r < 32; r++) if (m_pend[r]) begin idle(1, 5'(r)); break; end
    end
    idle(0, 0);
    chk("drained", {28'd0, o_inflight}, 32'd0);

    // Fault: x0 writeback is ignored, non-pending writeback is sticky.
    idle(1, 0);
    idle(1, 7);
    idle(0, 0);
    idle(0, 0);
    chk("fault_sticky", {31'd0, o_fault}, 32'd1);

    // Simultaneous issue/writeback on different registers, then reset mid-DRAIN.
    wr(4, 0, 0);
    wr(9, 1, 4);
    chk("sim_pend9", {31'd0, o_pending[9]}, 32'd1);
    chk("sim_pend4", {31'd0, o_pending[4]}, 32'd0);
    chk("sim_cnt",   {28'd0, o_inflight}, 32'd1);
    wr(6, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    chk("pre_rst_drain", 32'(dut.r_state), 32'd1);
    #1;
    i_reset = 1'b1;
    #1;
    chk("rst_pend",  o_pending, 32'd0);
    chk("rst_cnt",   {28'd0, o_inflight}, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd1);
    chk("rst_issue", {31'd0, o_issue}, 32'd0);
    i_valid = 1'b0; i_serialize = 1'b0;
    i_reset = 1'b0;
    model_reset();
    @(posedge i_clock); #1;
    wr(9, 0, 0);
    idle(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
